// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] definitions: slice geometry, chi stage states and
// the lane bit index within a 5x5 slice.
package keccak_pkg;

    localparam int SLICE_W    = 25;
    localparam int LINE_W     = 6;
    localparam int NUM_SLICES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int idx(input int x, input int y);
        return 5 * y + x;
    endfunction

endpackage

// File: rtl/chi_slice.sv
// Combinational chi over one 25-bit slice, built as five independent
// 5-bit rows: out[x] = in[x] ^ (~in[x+1] & in[x+2]) within each row.
module chi_slice
    import keccak_pkg::*;
(
    input  logic [SLICE_W-1:0] slice_i,
    output logic [SLICE_W-1:0] slice_o
);

    for (genvar y = 0; y < 5; y++) begin : g_row
        for (genvar x = 0; x < 5; x++) begin : g_bit
            assign slice_o[idx(x, y)] = slice_i[idx(x, y)]
                ^ (~slice_i[idx((x + 1) % 5, y)] & slice_i[idx((x + 2) % 5, y)]);
        end
    end

endmodule

// File: rtl/chi_stage.sv
// Chi step engine: reads slices 0..NUM_SLICES-1, writes chi results in order.
// Build option CHI_HOLD_EN adds a hold input that freezes the whole pipeline.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one source read per cycle, addresses 0..63
// DRAIN | reads done, waiting for the last write to land
// DONE  | finish pulse, back to IDLE next cycle
module chi_stage
    import keccak_pkg::*;
#(
    parameter int NUM_SLICES = keccak_pkg::NUM_SLICES,
    parameter int SLICE_W    = keccak_pkg::SLICE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef CHI_HOLD_EN
    input  logic               hold,
`endif
    output logic               finish,
    output logic               busy,
    output logic               rd_en,
    output logic [LINE_W-1:0]  rd_addr,
    input  logic [SLICE_W-1:0] rd_data,
    output logic               wr_en,
    output logic [LINE_W-1:0]  wr_addr,
    output logic [SLICE_W-1:0] wr_data
);

    localparam logic [LINE_W-1:0] LAST = LINE_W'(NUM_SLICES - 1);

    state_e             state_q, state_d;
    logic               rd_en_q, rd_en_d;
    logic [LINE_W-1:0]  rd_addr_q, rd_addr_d;
    logic               dval_q, dval_d;
    logic [LINE_W-1:0]  daddr_q, daddr_d;
    logic               wr_en_q, wr_en_d;
    logic [LINE_W-1:0]  wr_addr_q, wr_addr_d;
    logic [SLICE_W-1:0] wr_data_q, wr_data_d;
    logic               finish_q, finish_d;
    logic               busy_q, busy_d;
    logic [SLICE_W-1:0] chi_w;
    logic               hold_w;
    logic               freeze;

`ifdef CHI_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    // Hold is ignored in IDLE so a start under hold is still accepted.
    assign freeze = hold_w && (state_q != IDLE);

    chi_slice u_chi (
        .slice_i (rd_data),
        .slice_o (chi_w)
    );

    always_comb begin
        state_d   = state_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        dval_d    = dval_q;
        daddr_d   = daddr_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        finish_d  = finish_q;
        busy_d    = busy_q;
        if (!freeze) begin
            finish_d  = 1'b0;
            dval_d    = rd_en_q;
            daddr_d   = rd_addr_q;
            wr_en_d   = dval_q;
            wr_addr_d = daddr_q;
            if (dval_q) begin
                wr_data_d = chi_w;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = RUN;
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                    end
                end
                RUN: begin
                    if (rd_addr_q == LAST) begin
                        rd_en_d = 1'b0;
                        state_d = DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (wr_en_q && (wr_addr_q == LAST)) begin
                        state_d  = DONE;
                        finish_d = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
            busy_d = (state_d != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            dval_q    <= 1'b0;
            daddr_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            finish_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            dval_q    <= dval_d;
            daddr_q   <= daddr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            finish_q  <= finish_d;
            busy_q    <= busy_d;
        end
    end

    // Strobes drop during hold; the source memory keeps rd_data stable meanwhile.
    assign rd_en   = rd_en_q && !hold_w;
    assign wr_en   = wr_en_q && !hold_w;
    assign rd_addr = rd_addr_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign finish  = finish_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_chi_stage.sv
// Directed bench for chi_stage: source memory model, per-cycle capture of
// the outputs relative to the start edge, and scenario tasks.
module tb_chi_stage;

    localparam int NC = 160;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        finish, busy, rd_en, wr_en;
    logic [5:0]  rd_addr, wr_addr;
    logic [24:0] rd_data, wr_data;
`ifdef CHI_HOLD_EN
    logic        hold;
    int          hold_lo, hold_hi;
`endif

    logic [24:0] mem [0:63];
    logic [24:0] rd_q;

    int n_checks;
    int n_fail;
    int st1_c, st2_c, rst_c;

    logic        cap_rd_en   [0:NC-1];
    logic [5:0]  cap_rd_addr [0:NC-1];
    logic        cap_wr_en   [0:NC-1];
    logic [5:0]  cap_wr_addr [0:NC-1];
    logic [24:0] cap_wr_data [0:NC-1];
    logic        cap_fin     [0:NC-1];
    logic        cap_busy    [0:NC-1];

    always #5 clk = ~clk;

    chi_stage dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
`ifdef CHI_HOLD_EN
        .hold    (hold),
`endif
        .finish  (finish),
        .busy    (busy),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // Source memory: one-cycle read latency, output held while rd_en is low.
    always @(posedge clk) begin
        if (rd_en) rd_q <= mem[rd_addr];
    end
    assign rd_data = rd_q;

    function automatic logic [24:0] chi_model(input logic [24:0] s);
        logic [24:0] r;
        logic [4:0]  a, b, c;
        r = '0;
        for (int y = 0; y < 5; y++) begin
            a = s[5*y +: 5];
            b = {a[0], a[4:1]};
            c = {a[1:0], a[4:2]};
            r[5*y +: 5] = a ^ (~b & c);
        end
        return r;
    endfunction

    task automatic clear_sched();
        st1_c = -1;
        st2_c = -1;
        rst_c = -1;
`ifdef CHI_HOLD_EN
        hold_lo = -1;
        hold_hi = -2;
`endif
    endtask

    // Leaves the bench just after the start edge (cycle 0).
    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
    endtask

    // Cycle c values are those present just before edge c; inputs for cycle c
    // are driven 1 time unit after edge c-1 and outputs sampled on the negedge.
    task automatic capture(input int c_from, input int c_to);
        for (int c = c_from; c <= c_to; c++) begin
            #1;
            start = (c == st1_c) || (c == st2_c);
            rst   = (c == rst_c);
`ifdef CHI_HOLD_EN
            hold  = (c >= hold_lo) && (c <= hold_hi);
`endif
            @(negedge clk);
            cap_rd_en[c]   = rd_en;
            cap_rd_addr[c] = rd_addr;
            cap_wr_en[c]   = wr_en;
            cap_wr_addr[c] = wr_addr;
            cap_wr_data[c] = wr_data;
            cap_fin[c]     = finish;
            cap_busy[c]    = busy;
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        rst   = 1'b0;
`ifdef CHI_HOLD_EN
        hold  = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %b want 0", finish); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        n_checks++; if (rd_addr !== 6'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_checks++; if (wr_addr !== 6'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        n_checks++; if (wr_data !== 25'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_zero_timing();
        logic exp_rd, exp_wr, exp_busy, exp_fin;
        for (int i = 0; i < 64; i++) mem[i] = 25'h0;
        clear_sched();
        do_start();
        capture(1, 69);
        for (int c = 1; c <= 69; c++) begin
            exp_rd   = (c >= 1) && (c <= 64);
            exp_wr   = (c >= 3) && (c <= 66);
            exp_fin  = (c == 67);
            exp_busy = (c <= 67);
            n_checks++; if (cap_rd_en[c] !== exp_rd) begin n_fail++; $display("FAIL zero_rd_en c%0d: got %b want %b", c, cap_rd_en[c], exp_rd); end
            if (exp_rd) begin
                n_checks++; if (cap_rd_addr[c] !== 6'(c - 1)) begin n_fail++; $display("FAIL zero_rd_addr c%0d: got %0d want %0d", c, cap_rd_addr[c], c - 1); end
            end
            n_checks++; if (cap_wr_en[c] !== exp_wr) begin n_fail++; $display("FAIL zero_wr_en c%0d: got %b want %b", c, cap_wr_en[c], exp_wr); end
            if (exp_wr) begin
                n_checks++; if (cap_wr_addr[c] !== 6'(c - 3)) begin n_fail++; $display("FAIL zero_wr_addr c%0d: got %0d want %0d", c, cap_wr_addr[c], c - 3); end
                n_checks++; if (cap_wr_data[c] !== 25'h0) begin n_fail++; $display("FAIL zero_wr_data c%0d: got %h want 0", c, cap_wr_data[c]); end
            end
            n_checks++; if (cap_fin[c] !== exp_fin) begin n_fail++; $display("FAIL zero_finish c%0d: got %b want %b", c, cap_fin[c], exp_fin); end
            n_checks++; if (cap_busy[c] !== exp_busy) begin n_fail++; $display("FAIL zero_busy c%0d: got %b want %b", c, cap_busy[c], exp_busy); end
        end
    endtask

    task automatic test_vectors();
        for (int i = 0; i < 64; i++) mem[i] = 25'h0;
        mem[0] = 25'h0000001;
        mem[1] = 25'h0000002;
        mem[2] = 25'h1FFFFFF;
        mem[3] = 25'h0000000;
        clear_sched();
        do_start();
        capture(1, 69);
        n_checks++; if (cap_wr_addr[3] !== 6'd0 || cap_wr_data[3] !== 25'h0000009) begin n_fail++; $display("FAIL vec_slice0: got addr %0d data %h want addr 0 data 0000009", cap_wr_addr[3], cap_wr_data[3]); end
        n_checks++; if (cap_wr_addr[4] !== 6'd1 || cap_wr_data[4] !== 25'h0000012) begin n_fail++; $display("FAIL vec_slice1: got addr %0d data %h want addr 1 data 0000012", cap_wr_addr[4], cap_wr_data[4]); end
        n_checks++; if (cap_wr_addr[5] !== 6'd2 || cap_wr_data[5] !== 25'h1FFFFFF) begin n_fail++; $display("FAIL vec_slice2: got addr %0d data %h want addr 2 data 1ffffff", cap_wr_addr[5], cap_wr_data[5]); end
        n_checks++; if (cap_wr_addr[6] !== 6'd3 || cap_wr_data[6] !== 25'h0000000) begin n_fail++; $display("FAIL vec_slice3: got addr %0d data %h want addr 3 data 0", cap_wr_addr[6], cap_wr_data[6]); end
        n_checks++; if (cap_wr_en[66] !== 1'b1 || cap_wr_addr[66] !== 6'd63) begin n_fail++; $display("FAIL vec_last_write: got en %b addr %0d want en 1 addr 63", cap_wr_en[66], cap_wr_addr[66]); end
    endtask

    task automatic test_random();
        int nwr, nfin;
        for (int i = 0; i < 64; i++) mem[i] = 25'($urandom());
        clear_sched();
        do_start();
        capture(1, 69);
        nwr  = 0;
        nfin = 0;
        for (int c = 1; c <= 69; c++) begin
            if (cap_fin[c]) nfin++;
            if (cap_wr_en[c]) begin
                n_checks++; if (cap_wr_addr[c] !== 6'(nwr)) begin n_fail++; $display("FAIL rand_order c%0d: got addr %0d want %0d", c, cap_wr_addr[c], nwr); end
                n_checks++; if (cap_wr_data[c] !== chi_model(mem[cap_wr_addr[c]])) begin n_fail++; $display("FAIL rand_data addr%0d: got %h want %h", cap_wr_addr[c], cap_wr_data[c], chi_model(mem[cap_wr_addr[c]])); end
                nwr++;
            end
        end
        n_checks++; if (nwr !== 64) begin n_fail++; $display("FAIL rand_write_count: got %0d want 64", nwr); end
        n_checks++; if (nfin !== 1) begin n_fail++; $display("FAIL rand_finish_count: got %0d want 1", nfin); end
    endtask

    task automatic test_back_to_back();
        int nwr, nrd, nfin;
        clear_sched();
        st1_c = 20;
        st2_c = 68;
        do_start();
        capture(1, 70);
        nwr  = 0;
        nrd  = 0;
        nfin = 0;
        for (int c = 1; c <= 68; c++) begin
            if (cap_wr_en[c]) nwr++;
            if (cap_rd_en[c]) nrd++;
            if (cap_fin[c]) nfin++;
        end
        n_checks++; if (nwr !== 64) begin n_fail++; $display("FAIL b2b_write_count: got %0d want 64", nwr); end
        n_checks++; if (nrd !== 64) begin n_fail++; $display("FAIL b2b_read_count: got %0d want 64", nrd); end
        n_checks++; if (nfin !== 1) begin n_fail++; $display("FAIL b2b_finish_count: got %0d want 1", nfin); end
        n_checks++; if (cap_fin[67] !== 1'b1) begin n_fail++; $display("FAIL b2b_finish_c67: got %b want 1", cap_fin[67]); end
        n_checks++; if (cap_busy[68] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_c68: got %b want 0", cap_busy[68]); end
        n_checks++; if (cap_rd_en[69] !== 1'b1 || cap_rd_addr[69] !== 6'd0 || cap_busy[69] !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_c69: got rd_en %b addr %0d busy %b want 1 0 1", cap_rd_en[69], cap_rd_addr[69], cap_busy[69]); end
        clear_sched();
        capture(71, 140);
        nwr = 0;
        for (int c = 71; c <= 140; c++) begin
            if (cap_wr_en[c]) begin
                n_checks++; if (cap_wr_data[c] !== chi_model(mem[cap_wr_addr[c]])) begin n_fail++; $display("FAIL b2b_run2_data addr%0d: got %h want %h", cap_wr_addr[c], cap_wr_data[c], chi_model(mem[cap_wr_addr[c]])); end
                nwr++;
            end
        end
        n_checks++; if (nwr !== 64) begin n_fail++; $display("FAIL b2b_run2_write_count: got %0d want 64", nwr); end
        n_checks++; if (cap_fin[135] !== 1'b1) begin n_fail++; $display("FAIL b2b_run2_finish_c135: got %b want 1", cap_fin[135]); end
    endtask

    task automatic test_done_drop();
        int nrd;
        clear_sched();
        st1_c = 67;
        do_start();
        capture(1, 75);
        nrd = 0;
        for (int c = 68; c <= 75; c++) if (cap_rd_en[c] || cap_busy[c]) nrd++;
        n_checks++; if (nrd !== 0) begin n_fail++; $display("FAIL done_drop_activity: got %0d active cycles want 0", nrd); end
    endtask

    task automatic test_rst_mid();
        int nwr_pre, nwr_post, nfin;
        clear_sched();
        rst_c = 30;
        do_start();
        capture(1, 75);
        n_checks++; if ({cap_fin[31], cap_busy[31], cap_rd_en[31], cap_wr_en[31]} !== 4'b0000) begin n_fail++; $display("FAIL rst_strobes_c31: got fin/busy/rd/wr %b%b%b%b want 0000", cap_fin[31], cap_busy[31], cap_rd_en[31], cap_wr_en[31]); end
        n_checks++; if ({cap_rd_addr[31], cap_wr_addr[31], cap_wr_data[31]} !== 37'h0) begin n_fail++; $display("FAIL rst_buses_c31: got rd_addr %0d wr_addr %0d wr_data %h want 0", cap_rd_addr[31], cap_wr_addr[31], cap_wr_data[31]); end
        nwr_pre  = 0;
        nwr_post = 0;
        nfin     = 0;
        for (int c = 1; c <= 75; c++) begin
            if (cap_wr_en[c] && c <= 30) nwr_pre++;
            if (cap_wr_en[c] && c > 30) nwr_post++;
            if (cap_fin[c]) nfin++;
        end
        n_checks++; if (nwr_pre !== 28) begin n_fail++; $display("FAIL rst_writes_before: got %0d want 28", nwr_pre); end
        n_checks++; if (nwr_post !== 0) begin n_fail++; $display("FAIL rst_writes_after: got %0d want 0", nwr_post); end
        n_checks++; if (nfin !== 0) begin n_fail++; $display("FAIL rst_finish_count: got %0d want 0", nfin); end
        clear_sched();
        do_start();
        capture(1, 69);
        nwr_post = 0;
        for (int c = 1; c <= 69; c++) if (cap_wr_en[c]) nwr_post++;
        n_checks++; if (nwr_post !== 64) begin n_fail++; $display("FAIL rst_rerun_writes: got %0d want 64", nwr_post); end
        n_checks++; if (cap_fin[67] !== 1'b1) begin n_fail++; $display("FAIL rst_rerun_finish_c67: got %b want 1", cap_fin[67]); end
    endtask

`ifdef CHI_HOLD_EN
    task automatic test_hold();
        int nwr, nstrobe;
        clear_sched();
        hold_lo = 10;
        hold_hi = 14;
        do_start();
        capture(1, 75);
        nstrobe = 0;
        for (int c = 10; c <= 14; c++) if (cap_rd_en[c] || cap_wr_en[c]) nstrobe++;
        n_checks++; if (nstrobe !== 0) begin n_fail++; $display("FAIL hold_strobes: got %0d strobe cycles want 0", nstrobe); end
        nwr = 0;
        for (int c = 1; c <= 75; c++) begin
            if (cap_wr_en[c]) begin
                n_checks++; if (cap_wr_addr[c] !== 6'(nwr) || cap_wr_data[c] !== chi_model(mem[nwr])) begin n_fail++; $display("FAIL hold_write c%0d: got addr %0d data %h want addr %0d data %h", c, cap_wr_addr[c], cap_wr_data[c], nwr, chi_model(mem[nwr])); end
                nwr++;
            end
        end
        n_checks++; if (nwr !== 64) begin n_fail++; $display("FAIL hold_write_count: got %0d want 64", nwr); end
        n_checks++; if (cap_fin[72] !== 1'b1 || cap_fin[67] !== 1'b0) begin n_fail++; $display("FAIL hold_finish: got c67 %b c72 %b want 0 1", cap_fin[67], cap_fin[72]); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rd_q     = '0;
        start    = 1'b0;
        rst      = 1'b1;
`ifdef CHI_HOLD_EN
        hold     = 1'b0;
`endif
        for (int i = 0; i < 64; i++) mem[i] = 25'h0;
        clear_sched();
        test_reset();
        test_zero_timing();
        test_vectors();
        test_random();
        test_back_to_back();
        test_done_drop();
        test_rst_mid();
`ifdef CHI_HOLD_EN
        test_hold();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
